// File: rtl/digit_serial_alu.sv
// digit_serial_alu
//   Digit-serial adder/subtractor with an unsigned magnitude comparator.
//   Operands arrive LSB-first, DIGIT bits per accepted cycle, framed into
//   WORD-bit words. Each accepted digit produces a registered result digit
//   one cycle later. End-of-word flags hold until the next word completes.
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   in_valid   a/b digit valid this cycle
//   in_first   first (least significant) digit of a word, qualified by in_valid
//   mode       0 = A+B, 1 = A-B; sampled on the first digit only
//   a, b       operand digits
//   z          result digit
//   z_valid    z holds a valid digit (single cycle)
//   z_last     z is the most significant digit of the word (single cycle)
//   carry_out  final carry (add) or not-borrow (sub), held
//   a_eq_b     unsigned A==B of the completed word, held
//   a_lt_b     unsigned A<B of the completed word, held
//   frame_err  single-cycle pulse when a word is aborted by a premature in_first

module digit_serial_alu #(
  parameter int DIGIT = 2,
  parameter int WORD  = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             mode,
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic [DIGIT-1:0] z,
  output logic             z_valid,
  output logic             z_last,
  output logic             carry_out,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             frame_err
);

  localparam int NDIG = WORD / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_cur;
  logic            mode_r, c, k, eq;
  logic            start, take, last;
  logic            mode_eff, c_in, k_in, eq_in;
  logic [DIGIT:0]  sum, cmp;

  // One digit of ripple addition: {carry, sum} = x + y + cin.
  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             cin);
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  endfunction

  always_comb begin
    // Any in_first with in_valid starts a fresh word, even mid-word (abort).
    start    = in_valid & in_first;
    take     = in_valid & (in_first | (state == RUN));
    // On a first digit the chain seeds come from the inputs, not the registers.
    mode_eff = start ? mode : mode_r;
    c_in     = start ? mode : c;
    k_in     = start | k;
    eq_in    = start | eq;
    cnt_cur  = start ? '0 : cnt;
    last     = (cnt_cur == LAST_CNT);
    sum      = digit_add(a, mode_eff ? ~b : b, c_in);
    // Comparator is always a subtract: final carry 1 means A >= B.
    cmp      = digit_add(a, ~b, k_in);

    state_nxt = state;
    cnt_nxt   = cnt;
    if (take) begin
      if (last) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = cnt_cur + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Result stage: registered one cycle after the accepted digit.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mode_r    <= 1'b0;
      c         <= 1'b0;
      k         <= 1'b0;
      eq        <= 1'b1;
      z         <= '0;
      z_valid   <= 1'b0;
      z_last    <= 1'b0;
      carry_out <= 1'b0;
      a_eq_b    <= 1'b0;
      a_lt_b    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      z_valid   <= take;
      z_last    <= take & last;
      frame_err <= start & (state == RUN);
      if (take) begin
        z  <= sum[DIGIT-1:0];
        c  <= sum[DIGIT];
        k  <= cmp[DIGIT];
        eq <= eq_in & (a == b);
        if (start) mode_r <= mode;
        if (last) begin
          carry_out <= sum[DIGIT];
          a_eq_b    <= eq_in & (a == b);
          a_lt_b    <= ~cmp[DIGIT];
        end
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_alu.sv
// Testbench for digit_serial_alu (DIGIT=2, WORD=32). A word-level model
// predicts every output cycle; literal word results pin the model.

module tb_digit_serial_alu;

  localparam int D    = 2;
  localparam int W    = 32;
  localparam int NDIG = W / D;

  logic         clk = 1'b0;
  logic         clr;
  logic         in_valid, in_first, mode;
  logic [D-1:0] a, b;
  logic [D-1:0] z;
  logic         z_valid, z_last, carry_out, a_eq_b, a_lt_b, frame_err;

  digit_serial_alu #(.DIGIT(D), .WORD(W)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_first(in_first),
    .mode(mode), .a(a), .b(b), .z(z), .z_valid(z_valid), .z_last(z_last),
    .carry_out(carry_out), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Expected outputs after the next rising edge.
  logic [D-1:0] e_z;
  logic e_valid, e_last, e_ferr, e_co, e_eq, e_lt;

  // Model word state.
  bit          in_word;
  logic [31:0] wa, wb;
  bit          wm;

  // Collected from DUT outputs.
  logic [31:0] col, last_word, prev_word;
  int          idx, last_count, ferr_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f_res(input logic [31:0] x, input logic [31:0] y, input bit m);
    return m ? x - y : x + y;
  endfunction

  function automatic bit f_co(input logic [31:0] x, input logic [31:0] y, input bit m);
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, y};
    return m ? (x >= y) : s[32];
  endfunction

  // Drive one cycle and record what the outputs must be after the edge.
  task automatic step(input bit v, input bit f, input logic [31:0] x,
                      input logic [31:0] y, input bit m, input int i);
    logic [31:0] r;
    @(negedge clk);
    in_valid = v;
    in_first = f;
    mode     = f ? m : ~m;
    a        = v ? x[i*D +: D] : D'($urandom);
    b        = v ? y[i*D +: D] : D'($urandom);
    e_valid  = 1'b0;
    e_last   = 1'b0;
    e_ferr   = 1'b0;
    if (v) begin
      if (f) begin
        e_ferr  = in_word;
        in_word = 1'b1;
        wa = x; wb = y; wm = m;
      end
      if (in_word) begin
        r       = f_res(wa, wb, wm);
        e_valid = 1'b1;
        e_z     = r[i*D +: D];
        if (i == NDIG - 1) begin
          e_last  = 1'b1;
          e_co    = f_co(wa, wb, wm);
          e_eq    = (wa == wb);
          e_lt    = (wa < wb);
          in_word = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
  endtask

  task automatic send_word(input logic [31:0] x, input logic [31:0] y, input bit m,
                           input bit stall, input int ndig);
    for (int i = 0; i < ndig; i++) begin
      if (stall && (i % 4 == 2)) idle($urandom_range(1, 3));
      step(1'b1, i == 0, x, y, m, i);
    end
  endtask

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    #1;
    chk("z_valid", z_valid, e_valid);
    chk("z_last", z_last, e_last);
    chk("frame_err", frame_err, e_ferr);
    chk("carry_out", carry_out, e_co);
    chk("a_eq_b", a_eq_b, e_eq);
    chk("a_lt_b", a_lt_b, e_lt);
    if (e_valid) chk("z", z, e_z);
    if (!clr) idx = 0;
    if (frame_err) begin
      ferr_count++;
      idx = 0;
    end
    if (z_valid && idx < NDIG) begin
      col[idx*D +: D] = z;
      idx++;
    end
    if (z_last) begin
      prev_word = last_word;
      last_word = col;
      last_count++;
      idx = 0;
    end
  end

  int lc0, fc0;

  initial begin
    clr = 1'b0; in_valid = 1'b0; in_first = 1'b0; mode = 1'b0; a = '0; b = '0;
    e_z = '0; e_valid = 0; e_last = 0; e_ferr = 0; e_co = 0; e_eq = 0; e_lt = 0;
    in_word = 0; wa = '0; wb = '0; wm = 0;
    col = '0; last_word = '0; prev_word = '0; idx = 0; last_count = 0; ferr_count = 0;

    repeat (2) @(negedge clk);
    chk("reset_z", z, 0);
    chk("reset_valid", z_valid, 0);
    clr = 1'b1;

    // Model pins.
    chk("model_add", f_res(32'h37353AF2, 32'h1, 0), 32'h37353AF3);
    chk("model_sub_co", f_co(32'h1, 32'h2, 1), 0);
    chk("model_ovf_co", f_co(32'hFFFFFFFF, 32'h1, 0), 1);

    // Plain add.
    send_word(32'h37353AF2, 32'h00000001, 0, 0, NDIG); idle(1);
    chk("add_word", last_word, 32'h37353AF3);
    chk("add_co", carry_out, 0);
    chk("add_eq", a_eq_b, 0);
    chk("add_lt", a_lt_b, 0);

    // Add overflow.
    send_word(32'hFFFFFFFF, 32'h00000001, 0, 0, NDIG); idle(1);
    chk("ovf_word", last_word, 32'h00000000);
    chk("ovf_co", carry_out, 1);
    chk("ovf_lt", a_lt_b, 0);

    // Subtract.
    send_word(32'h37353AF2, 32'h00000001, 1, 0, NDIG); idle(1);
    chk("sub_word", last_word, 32'h37353AF1);
    chk("sub_co", carry_out, 1);

    // Equal operands.
    send_word(32'h12345678, 32'h12345678, 1, 0, NDIG); idle(1);
    chk("eq_word", last_word, 32'h0);
    chk("eq_co", carry_out, 1);
    chk("eq_eq", a_eq_b, 1);
    chk("eq_lt", a_lt_b, 0);

    // A < B.
    send_word(32'h1, 32'h2, 1, 0, NDIG); idle(1);
    chk("lt_word", last_word, 32'hFFFFFFFF);
    chk("lt_co", carry_out, 0);
    chk("lt_lt", a_lt_b, 1);
    chk("lt_eq", a_eq_b, 0);

    // Stalls, then a back-to-back word.
    lc0 = last_count;
    send_word(32'h37353AF2, 32'h00000001, 0, 1, NDIG);
    send_word(32'h00000005, 32'h00000003, 1, 0, NDIG); idle(1);
    chk("b2b_count", last_count - lc0, 2);
    chk("stall_word", prev_word, 32'h37353AF3);
    chk("b2b_word", last_word, 32'h00000002);
    chk("b2b_co", carry_out, 1);

    // Abort at digit 5.
    lc0 = last_count; fc0 = ferr_count;
    send_word(32'h11111111, 32'h22222222, 0, 0, 5);
    send_word(32'hFFFFFFFF, 32'h00000001, 0, 0, NDIG); idle(1);
    chk("abort_ferr_count", ferr_count - fc0, 1);
    chk("abort_last_count", last_count - lc0, 1);
    chk("abort_word", last_word, 32'h0);
    chk("abort_co", carry_out, 1);

    // Asynchronous reset mid-word.
    lc0 = last_count;
    send_word(32'hAAAA5555, 32'h12345678, 0, 0, 8);
    @(posedge clk); #2;
    clr = 1'b0;
    e_valid = 0; e_last = 0; e_ferr = 0; e_co = 0; e_eq = 0; e_lt = 0;
    in_word = 0;
    #1;
    chk("arst_z", z, 0);
    chk("arst_valid", z_valid, 0);
    chk("arst_co", carry_out, 0);
    chk("arst_eq", a_eq_b, 0);
    chk("arst_lt", a_lt_b, 0);
    idle(2);
    clr = 1'b1;
    for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 32'h5555AAAA, 32'h1, 0, j);
    send_word(32'h0000ABCD, 32'h00001234, 0, 0, NDIG); idle(1);
    chk("post_rst_count", last_count - lc0, 1);
    chk("post_rst_word", last_word, 32'h0000BE01);
    chk("post_rst_co", carry_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/digit_serial_alu.md
Name: digit_serial_alu

Overview:
- Parametrised successor to the team's 1-bit serial line adder.
- Accepts two operands LSB-first, DIGIT bits per clock, framed into WORD-bit words.
- Supports add or subtract, with a registered DIGIT-wide result stream.
- Reports end-of-word carry/borrow, unsigned equal/less-than flags and framing errors; sits between the serial line deserialiser front end and downstream word collectors.

Parameters:
DIGIT, 2, bits per operand per accepted cycle (>=1)
WORD, 32, operand word length in bits; must be a multiple of DIGIT; NDIG = WORD/DIGIT digits per word

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset
in_valid  input  1  a/b digit valid this cycle
in_first  input  1  qualifies first (least significant) digit of a word; meaningful only with in_valid
mode  input  1  0 = add (A+B), 1 = subtract (A-B); sampled only on the first digit
a  input  DIGIT  operand A digit, LSB-first order
b  input  DIGIT  operand B digit, LSB-first order
z  output  DIGIT  result digit
z_valid  output  1  z holds a valid digit
z_last  output  1  z is the final (most significant) digit of the word
carry_out  output  1  final carry (add) or not-borrow (sub); valid with z_last
a_eq_b  output  1  unsigned A==B for the completed word; valid with z_last
a_lt_b  output  1  unsigned A<B for the completed word; valid with z_last
frame_err  output  1  one-cycle pulse: word aborted by a premature in_first

Behaviour:
- Reset (clr=0, async): state IDLE, digit counter 0, carry/borrow registers 0, eq register 1. Outputs z, z_valid, z_last, carry_out, a_eq_b, a_lt_b and frame_err are all 0. A word in progress is discarded; no z_last is produced for it.
- FSM states are IDLE and RUN.
- IDLE:
  - in_valid & in_first: start a word. Latch mode. Carry init = mode. Borrow-compare init 1, eq init 1. Process the digit; counter = 1; go to RUN.
  - If NDIG==1, this digit is the last digit; stay in IDLE.
  - in_valid without in_first: ignored; no output.
- RUN:
  - in_valid=0: stall; all state held; z_valid=0 next cycle.
  - in_valid & ~in_first: process the digit; counter++.
  - Last digit (counter==NDIG-1): process it, then counter=0 and go to IDLE.
  - in_valid & in_first (premature): abort the current word; frame_err=1 next cycle. Treat the digit as the first digit of a new word, with mode re-latched and counter = 1.
- Digit processing uses DIGIT+1-bit arithmetic:
  - {c', s} = a + (mode ? ~b : b) + c; c <= c'.
  - Compare path runs independently of mode: {k', d} = a + ~b + k; k <= k'.
  - eq <= eq & (a==b).
- Latency:
  - z <= s and z_valid=1 on the clock edge that accepts the digit, so the result is available one cycle after the input.
  - On the last digit, the same edge sets z_last=1, carry_out=c', a_eq_b=eq&(a==b), a_lt_b=~k'.
  - z_last, frame_err and z_valid are single-cycle.
  - carry_out, a_eq_b and a_lt_b hold until the next z_last or reset.
- Back-to-back words: in_first with in_valid is accepted on the cycle immediately after a last digit; no bubble is required.
- Widths: no internal saturation; results wrap modulo 2^WORD. Overflow is indicated only via carry_out.

Test Plan:
- Add, DIGIT=2/WORD=32: A=0x37353AF2, B=0x00000001, mode=0, continuous in_valid. Required: 16 z digits reassembling 0x37353AF3; z_last on the 16th digit; carry_out=0, a_eq_b=0, a_lt_b=0; first z_valid 1 cycle after the first digit.
- Add overflow: A=0xFFFFFFFF, B=0x00000001, mode=0. Required: Z=0x00000000, carry_out=1, a_lt_b=0. Subtract: A=0x37353AF2, B=1, mode=1. Required: Z=0x37353AF1, carry_out=1.
- Compare via subtract:
  - A=B=0x12345678. Required: Z=0, carry_out=1, a_eq_b=1, a_lt_b=0.
  - A=1, B=2. Required: Z=0xFFFFFFFF, carry_out=0, a_lt_b=1, a_eq_b=0.
- Stalls and back-to-back: random in_valid gaps within the 0x37353AF2+1 word. Required: identical digit sequence; z_valid only after valid inputs. Follow immediately with a second word started the next cycle; required: both z_last pulses, correct second result.
- Abort: in_first asserted at digit 5 of a word. Required: frame_err single pulse, no z_last for the aborted word, and the new word (A=0xFFFFFFFF+B=1) yields Z=0 with carry_out=1.
- Reset mid-word: clr low at digit 8, then release. Required: all outputs 0 immediately (async). In_valid without in_first is ignored until the next in_first; a following clean word completes correctly.
